spi_master_shift: RTL and testbench

- SPI master shift engine in the spi_clk domain, directly downstream of the APB/SPI enable/ready synchronizer.
- Consumes the synchronized level spi_enable as a four-phase request and runs one full-duplex transfer of DATA_W bits in SPI mode 0 (CPOL=0, CPHA=0).
- Returns spi_ready as a level acknowledge, which the synchronizer carries back to pclk as pready.
- tx_data and rx_data are quasi-static buses shared with the APB register file.

---
 rtl/spi_master_shift.sv | 144 ++++++++++++++
 tb/tb_spi_master_shift.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_master_shift.sv
// SPI mode-0 master shift engine driven by a four-phase spi_enable/spi_ready handshake.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting; default is MSB first.
module spi_master_shift #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              spi_clk,
  input  logic              preset_n,
  input  logic              spi_enable,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              spi_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi
);

  localparam int              BCW       = $clog2(DATA_W) + 1;
  localparam logic [7:0]      HP_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [BCW-1:0]  BIT_LAST  = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0]  BIT_ALL   = BCW'(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t              state_reg;
  logic [7:0]          hp_cnt_reg;
  logic [BCW-1:0]      bit_cnt_reg;
  logic [DATA_W-1:0]   tx_shift_reg;
  logic [DATA_W-1:0]   rx_shift_reg;
  logic [DATA_W-1:0]   rx_data_reg;
  logic                sclk_reg;
  logic                ss_n_reg;
  logic                busy_reg;
  logic                ready_reg;

`ifdef SPI_LSB_FIRST_EN
  localparam int MOSI_BIT = 0;

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v);
    return {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b);
    return {b, v[DATA_W-1:1]};
  endfunction
`else
  localparam int MOSI_BIT = DATA_W - 1;

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b);
    return {v[DATA_W-2:0], b};
  endfunction
`endif

  // mosi is taken straight from the tx shift flop; clearing the register idles mosi low.
  assign mosi      = tx_shift_reg[MOSI_BIT];
  assign sclk      = sclk_reg;
  assign ss_n      = ss_n_reg;
  assign busy      = busy_reg;
  assign spi_ready = ready_reg;
  assign rx_data   = rx_data_reg;

  always_ff @(posedge spi_clk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg    <= IDLE;
      hp_cnt_reg   <= '0;
      bit_cnt_reg  <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      sclk_reg     <= 1'b0;
      ss_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (spi_enable) begin
            tx_shift_reg <= tx_data;
            rx_shift_reg <= '0;
            ss_n_reg     <= 1'b0;
            busy_reg     <= 1'b1;
            hp_cnt_reg   <= HP_RELOAD;
            bit_cnt_reg  <= '0;
            state_reg    <= SETUP;
          end
        end
        SETUP: begin
          if (hp_cnt_reg == 8'd0) begin
            sclk_reg   <= 1'b1;
            hp_cnt_reg <= HP_RELOAD;
            state_reg  <= SHIFT;
          end else begin
            hp_cnt_reg <= hp_cnt_reg - 8'd1;
          end
        end
        SHIFT: begin
          if (hp_cnt_reg != 8'd0) begin
            hp_cnt_reg <= hp_cnt_reg - 8'd1;
          end else begin
            hp_cnt_reg <= HP_RELOAD;
            if (sclk_reg) begin
              sclk_reg     <= 1'b0;
              rx_shift_reg <= shift_rx(rx_shift_reg, miso);
              bit_cnt_reg  <= bit_cnt_reg + BCW'(1);
              if (bit_cnt_reg != BIT_LAST)
                tx_shift_reg <= shift_tx(tx_shift_reg);
            end else if (bit_cnt_reg == BIT_ALL) begin
              // trailing low half-period after the last fall is over
              state_reg <= HOLD;
            end else begin
              sclk_reg <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hp_cnt_reg == 8'd0) begin
            ss_n_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            tx_shift_reg <= '0;
            rx_data_reg  <= rx_shift_reg;
            ready_reg    <= 1'b1;
            state_reg    <= DONE;
          end else begin
            hp_cnt_reg <= hp_cnt_reg - 8'd1;
          end
        end
        DONE: begin
          if (!spi_enable) begin
            ready_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shift.sv
// Directed bench for spi_master_shift: CLK_DIV=2 and CLK_DIV=1 instances, table-driven transfers.
module tb_spi_master_shift;

  logic       clk = 1'b0;
  logic       preset_n;
  logic       en_a, en_b, miso_a, miso_b;
  logic [7:0] tx_a, tx_b;
  logic       ready_a, ready_b, busy_a, busy_b, sclk_a, sclk_b, ss_n_a, ss_n_b, mosi_a, mosi_b;
  logic [7:0] rx_a, rx_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_master_shift #(.DATA_W(8), .CLK_DIV(2)) dut_a (
    .spi_clk(clk), .preset_n(preset_n), .spi_enable(en_a), .tx_data(tx_a), .miso(miso_a),
    .spi_ready(ready_a), .rx_data(rx_a), .busy(busy_a), .sclk(sclk_a), .ss_n(ss_n_a), .mosi(mosi_a)
  );

  spi_master_shift #(.DATA_W(8), .CLK_DIV(1)) dut_b (
    .spi_clk(clk), .preset_n(preset_n), .spi_enable(en_b), .tx_data(tx_b), .miso(miso_b),
    .spi_ready(ready_b), .rx_data(rx_b), .busy(busy_b), .sclk(sclk_b), .ss_n(ss_n_b), .mosi(mosi_b)
  );

  typedef struct {
    logic [7:0] tx;
    int         mode;     // 0 loopback, 1 miso tied 1, 2 miso tied 0
    logic [7:0] exp_rx;
    logic [7:0] exp_pat;  // mosi bits in transmit order, assembled in shift order
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_miso(input bit sel, input int mode, input logic m);
    logic v;
    v = (mode == 0) ? m : (mode == 1) ? 1'b1 : 1'b0;
    if (sel) miso_b = v; else miso_a = v;
  endtask

  // Called at a negedge: raises enable now, follows the transfer until spi_ready.
  task automatic xfer(input bit sel, input logic [7:0] tx, input int mode,
                      output int lat, output logic [7:0] pat, output int rises, output int span);
    logic prev_sclk, s_sclk, s_mosi, s_rdy;
    int   first_rise, last_rise;
    lat = -1; pat = '0; rises = 0; first_rise = 0; last_rise = 0; prev_sclk = 1'b0;
    drive_miso(sel, mode, 1'b0);
    if (sel) begin tx_b = tx; en_b = 1'b1; end else begin tx_a = tx; en_a = 1'b1; end
    for (int cnt = 1; cnt <= 400 && lat < 0; cnt++) begin
      @(negedge clk);
      s_sclk = sel ? sclk_b  : sclk_a;
      s_mosi = sel ? mosi_b  : mosi_a;
      s_rdy  = sel ? ready_b : ready_a;
      if (cnt == 1) begin
        check("ss_n_low_at_e0", {31'd0, sel ? ss_n_b : ss_n_a}, 32'd0);
        check("busy_at_e0", {31'd0, sel ? busy_b : busy_a}, 32'd1);
      end
      if (cnt == 2) begin
        if (sel) tx_b = ~tx; else tx_a = ~tx;
      end
      if (s_sclk && !prev_sclk) begin
        rises++;
`ifdef SPI_LSB_FIRST_EN
        pat = {s_mosi, pat[7:1]};
`else
        pat = {pat[6:0], s_mosi};
`endif
        if (rises == 1) first_rise = cnt;
        last_rise = cnt;
      end
      prev_sclk = s_sclk;
      if (s_rdy) lat = cnt - 1;
      drive_miso(sel, mode, s_mosi);
    end
    span = last_rise - first_rise;
    if (lat < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[6];
  int   lat, rises, span;
  logic [7:0] pat;

  initial begin
    vecs[0] = '{tx: 8'hA5, mode: 0, exp_rx: 8'hA5, exp_pat: 8'hA5};
    vecs[1] = '{tx: 8'h3C, mode: 1, exp_rx: 8'hFF, exp_pat: 8'h3C};
    vecs[2] = '{tx: 8'h3C, mode: 2, exp_rx: 8'h00, exp_pat: 8'h3C};
    vecs[3] = '{tx: 8'h12, mode: 0, exp_rx: 8'h12, exp_pat: 8'h12};
    vecs[4] = '{tx: 8'h34, mode: 0, exp_rx: 8'h34, exp_pat: 8'h34};
    vecs[5] = '{tx: 8'h01, mode: 0, exp_rx: 8'h01, exp_pat: 8'h01};

    preset_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; miso_a = 1'b0; miso_b = 1'b0; tx_a = '0; tx_b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_ss_n",  {31'd0, ss_n_a},  32'd1);
    check("rst_sclk",  {31'd0, sclk_a},  32'd0);
    check("rst_mosi",  {31'd0, mosi_a},  32'd0);
    check("rst_busy",  {31'd0, busy_a},  32'd0);
    check("rst_rx",    {24'd0, rx_a},    32'd0);
    preset_n = 1'b1;
    @(negedge clk);

    // Back-to-back transfers on the CLK_DIV=2 instance, enable low one cycle between them.
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, vecs[i].tx, vecs[i].mode, lat, pat, rises, span);
      $display("xfer a%0d tx=0x%02h rx=0x%02h pat=0x%02h lat=%0d", i, vecs[i].tx, rx_a, pat, lat);
      check("a_latency", lat, 32'd36);
      check("a_rx_data", {24'd0, rx_a}, {24'd0, vecs[i].exp_rx});
      check("a_mosi_pattern", {24'd0, pat}, {24'd0, vecs[i].exp_pat});
      check("a_sclk_pulses", rises, 32'd8);
      check("a_sclk_span", span, 32'd28);
      check("a_done_ss_n", {31'd0, ss_n_a}, 32'd1);
      check("a_done_busy", {31'd0, busy_a}, 32'd0);
      check("a_done_mosi", {31'd0, mosi_a}, 32'd0);
      en_a = 1'b0;
      @(negedge clk);
      check("a_ready_drop", {31'd0, ready_a}, 32'd0);
      check("a_idle_ss_n", {31'd0, ss_n_a}, 32'd1);
      check("a_idle_rx_hold", {24'd0, rx_a}, {24'd0, vecs[i].exp_rx});
    end

    // CLK_DIV=1: shorter latency, then enable held high across DONE.
    xfer(1'b1, 8'hC3, 0, lat, pat, rises, span);
    $display("xfer b tx=0xc3 rx=0x%02h pat=0x%02h lat=%0d", rx_b, pat, lat);
    check("b_latency", lat, 32'd18);
    check("b_rx_data", {24'd0, rx_b}, 32'h0000_00C3);
    check("b_mosi_pattern", {24'd0, pat}, 32'h0000_00C3);
    check("b_sclk_span", span, 32'd14);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("b_hold_ready", {31'd0, ready_b}, 32'd1);
      check("b_hold_sclk", {31'd0, sclk_b}, 32'd0);
      check("b_hold_ss_n", {31'd0, ss_n_b}, 32'd1);
    end
    en_b = 1'b0;
    @(negedge clk);
    check("b_ready_drop", {31'd0, ready_b}, 32'd0);

    // Reset in the middle of a transfer.
    miso_a = 1'b0;
    tx_a = 8'h5A;
    en_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      miso_a = mosi_a;
    end
    check("mid_busy_before_rst", {31'd0, busy_a}, 32'd1);
    preset_n = 1'b0;
    en_a = 1'b0;
    #1;
    check("mid_rst_sclk",  {31'd0, sclk_a},  32'd0);
    check("mid_rst_ss_n",  {31'd0, ss_n_a},  32'd1);
    check("mid_rst_ready", {31'd0, ready_a}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy_a},  32'd0);
    check("mid_rst_rx",    {24'd0, rx_a},    32'd0);
    @(negedge clk);
    preset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_ss_n", {31'd0, ss_n_a}, 32'd1);
    xfer(1'b0, 8'h96, 0, lat, pat, rises, span);
    $display("xfer a_post_rst tx=0x96 rx=0x%02h pat=0x%02h lat=%0d", rx_a, pat, lat);
    check("post_rst_latency", lat, 32'd36);
    check("post_rst_rx", {24'd0, rx_a}, 32'h0000_0096);
    check("post_rst_pulses", rises, 32'd8);
    en_a = 1'b0;
    @(negedge clk);
    check("post_rst_ready_drop", {31'd0, ready_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
